mem_stim_seq: RTL and testbench
===============================

# mem_stim_seq

Synthesizable memory-command sequencer: a parametrised command buffer loaded over a valid/ready port, then replayed onto a memory request bus (address, write, enable, write data) at one entry per clock. It generalises our queue-driven address/wr/en stimulus into reusable RTL with configurable widths and depth, loop replay, abort, and a pass counter. It sits between a host/test controller and a memory model or controller under test.

## Interface
- ADDR_W, 6, address width
- DATA_W, 8, write-data width
- DEPTH, 8, command buffer entries (≥2, power of two not required)
- CNT_W, 16, pass-counter width
- clk  in  1  clock, all activity on rising edge
- rst  in  1  synchronous, active-high reset
- push_valid  in  1  host offers a command
- push_ready  out  1  buffer accepts a command this cycle
- push_addr  in  ADDR_W  command address
- push_wr  in  1  command write flag (1 = write, 0 = read)
- push_data  in  DATA_W  command write data
- start  in  1  begin replay
- loop_en  in  1  replay continuously while high
- stop  in  1  abort replay
- clear  in  1  empty the buffer, return to LOAD
- mem_addr  out  ADDR_W  registered request address
- mem_wr  out  1  registered request write flag
- mem_en  out  1  registered request valid
- mem_wdata  out  DATA_W  registered request write data
- busy  out  1  high in RUN
- done  out  1  high in DONE
- count  out  $clog2(DEPTH+1)  entries loaded
- pass_cnt  out  CNT_W  completed full passes, saturating

## Operation
- States: LOAD, RUN, DONE. Reset → LOAD.
- LOAD: push_ready = (count < DEPTH), combinational. Push fires on push_valid && push_ready: entry written at index count, count += 1.
- LOAD + start with count > 0 (pre-edge): → RUN, rd_ptr = 0, pass_cnt = 0; entry 0 issued on the same edge. Simultaneous push is accepted and becomes the last entry of the run.
- LOAD + start with count == 0: start ignored; simultaneous push still accepted.
- LOAD + clear: count = 0 (clear beats push and start).
- RUN: push_ready = 0. Each edge issues entry rd_ptr onto mem_* with mem_en = 1, rd_ptr += 1.
- End of pass (entry count-1 issued): pass_cnt += 1 (saturates at all-ones). Next edge: if loop_en → issue entry 0 (wrap, no bubble); else → DONE, mem_en = 0.
- loop_en is sampled at the end-of-pass edge only.
- stop in RUN: → DONE on that edge, no entry issued, mem_en = 0; stop outranks issue. Partial pass not counted.
- DONE: done = 1, mem_* all zero, buffer contents and count retained. start → RUN again (replay, pass_cnt reset to 0). clear → LOAD, count = 0. clear outranks start.
- stop/clear outside their states: ignored (except clear in LOAD).
- When mem_en = 0, mem_addr, mem_wr, mem_wdata are driven 0.

## Timing
- Reset values: mem_addr 0, mem_wr 0, mem_en 0, mem_wdata 0, busy 0, done 0, count 0, pass_cnt 0, push_ready 1 (LOAD, empty). Buffer contents need not reset.
- rst mid-run: next edge all outputs at reset values, state LOAD, count 0.
- start sampled at edge N → entry k on mem_* for cycle after edge N+k, k = 0..count-1.
- Non-loop: mem_en falls and done rises after edge N+count. busy = 1 for exactly count cycles.
- Loop: entry 0 reappears after edge N+count; throughput one entry/cycle indefinitely.
- Push throughput one per cycle; DEPTH-th push drives push_ready low the following cycle.

## Test plan
- Load 5 commands addr {12,14,23,48,56}, wr {1,1,0,0,0}, data {0xA0..0xA4}; start, loop_en=0 -> mem_en high 5 consecutive cycles with those values in order, then done=1, busy=0, pass_cnt=1.
- Push DEPTH+2 commands back-to-back with push_valid held -> exactly DEPTH accepted, push_ready=0 after DEPTH, count=DEPTH.
- Same 5 commands, loop_en=1 for 12 cycles then stop -> sequence 12,14,23,48,56,12,14,… with no bubble at wrap; mem_en=0 the cycle after stop; pass_cnt=2.
- start with count=0 plus simultaneous push -> stays LOAD, count=1, mem_en=0; start next cycle -> single entry issued, done.
- rst asserted during RUN at entry 2 -> next cycle all outputs at reset values, count=0; DONE+start replays identical sequence; DONE+clear+start -> start ignored.
- CNT_W=2 loop for 5 passes -> pass_cnt saturates at 3.

Source files
------------

// File: rtl/mem_stim_seq_if.sv
// Command-push handshake and registered memory request bus for mem_stim_seq.
interface mem_stim_seq_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              push_valid;
    logic              push_ready;
    logic [ADDR_W-1:0] push_addr;
    logic              push_wr;
    logic [DATA_W-1:0] push_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic              mem_en;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  push_valid, push_addr, push_wr, push_data,
        output push_ready, mem_addr, mem_wr, mem_en, mem_wdata
    );

    modport master (
        output push_valid, push_addr, push_wr, push_data,
        input  push_ready, mem_addr, mem_wr, mem_en, mem_wdata
    );
endinterface

// File: rtl/mem_stim_seq.sv
// Memory-command sequencer: buffers pushed commands, then replays them onto the
// request bus one per clock, optionally looping, with a saturating pass counter.
//
// state | meaning
// LOAD  | accepting pushes into the buffer
// RUN   | issuing one buffered entry per clock
// DONE  | replay finished or aborted, buffer retained
module mem_stim_seq #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    mem_stim_seq_if.slave              bus,
    input  logic                       start,
    input  logic                       loop_en,
    input  logic                       stop,
    input  logic                       clear,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           pass_cnt
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = ADDR_W + 1 + DATA_W;
    localparam logic [CW-1:0]    FULL     = CW'(DEPTH);
    localparam logic [CW-1:0]    ONE      = CW'(1);
    localparam logic [CNT_W-1:0] PASS_ONE = CNT_W'(1);

    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [EW-1:0]    buf_q [DEPTH];
    logic [EW-1:0]    entry;
    logic [CW-1:0]    rd_ptr, rd_ptr_nxt, count_nxt, idx;
    logic [CNT_W-1:0] pass_nxt;
    logic             push_fire, issue, last;

    assign bus.push_ready = (state == LOAD) && (count < FULL);
    assign push_fire      = bus.push_valid && bus.push_ready;
    assign busy           = (state == RUN);
    assign done           = (state == DONE);
    assign entry          = buf_q[idx[AW-1:0]];

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        rd_ptr_nxt = rd_ptr;
        pass_nxt   = pass_cnt;
        idx        = '0;
        issue      = 1'b0;
        case (state)
            LOAD: begin
                if (clear) begin
                    count_nxt = '0;
                end else begin
                    if (push_fire) count_nxt = count + ONE;
                    if (start && (count != '0)) begin
                        state_nxt = RUN;
                        issue     = 1'b1;
                        pass_nxt  = '0;
                    end
                end
            end
            RUN: begin
                // rd_ptr == count means the last entry went out on the previous edge
                if (stop) begin
                    state_nxt = DONE;
                end else if ((rd_ptr != count) || loop_en) begin
                    issue = 1'b1;
                    idx   = (rd_ptr == count) ? '0 : rd_ptr;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (clear) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                end else if (start) begin
                    state_nxt = RUN;
                    issue     = 1'b1;
                    pass_nxt  = '0;
                end
            end
            default: state_nxt = LOAD;
        endcase
        last = issue && (idx == (count_nxt - ONE));
        if (issue) rd_ptr_nxt = idx + ONE;
        if (last && (pass_nxt != '1)) pass_nxt = pass_nxt + PASS_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LOAD;
            count         <= '0;
            rd_ptr        <= '0;
            pass_cnt      <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wr    <= 1'b0;
            bus.mem_wdata <= '0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            rd_ptr        <= rd_ptr_nxt;
            pass_cnt      <= pass_nxt;
            bus.mem_en    <= issue;
            bus.mem_addr  <= issue ? entry[EW-1 -: ADDR_W] : '0;
            bus.mem_wr    <= issue ? entry[DATA_W] : 1'b0;
            bus.mem_wdata <= issue ? entry[DATA_W-1:0] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) buf_q[count[AW-1:0]] <= {bus.push_addr, bus.push_wr, bus.push_data};
    end
endmodule

// File: tb/tb_mem_stim_seq.sv
// Directed bench for mem_stim_seq: expected requests are queued as replays are
// started and popped as the DUT issues them; a CNT_W=2 copy checks saturation.
module tb_mem_stim_seq;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, loop_en = 1'b0, stop = 1'b0, clear = 1'b0;
    logic              push_valid = 1'b0;
    logic [ADDR_W-1:0] push_addr  = '0;
    logic              push_wr    = 1'b0;
    logic [DATA_W-1:0] push_data  = '0;

    logic          busy, done, busy_s, done_s;
    logic [CW-1:0] count, count_s;
    logic [15:0]   pass_cnt;
    logic [1:0]    pass_s;

    int   n_assert = 0;
    int   n_fail   = 0;
    ent_t exp_q [$];
    ent_t mdl [$];

    logic [ADDR_W-1:0] a5 [5] = '{6'd12, 6'd14, 6'd23, 6'd48, 6'd56};
    logic              w5 [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    mem_stim_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_stim_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_s ();

    assign bus.push_valid   = push_valid;
    assign bus.push_addr    = push_addr;
    assign bus.push_wr      = push_wr;
    assign bus.push_data    = push_data;
    assign bus_s.push_valid = push_valid;
    assign bus_s.push_addr  = push_addr;
    assign bus_s.push_wr    = push_wr;
    assign bus_s.push_data  = push_data;

    always #5 clk = ~clk;

    mem_stim_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .start(start), .loop_en(loop_en),
        .stop(stop), .clear(clear), .busy(busy), .done(done), .count(count),
        .pass_cnt(pass_cnt)
    );

    mem_stim_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s), .start(start), .loop_en(loop_en),
        .stop(stop), .clear(clear), .busy(busy_s), .done(done_s), .count(count_s),
        .pass_cnt(pass_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score whatever the main DUT put on the request bus.
    task automatic tick();
        ent_t e;
        @(posedge clk);
        #1;
        if (bus.mem_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {31'd0, bus.mem_en}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("mem_addr", {26'd0, bus.mem_addr}, {26'd0, e.addr});
                chk("mem_wr", {31'd0, bus.mem_wr}, {31'd0, e.wr});
                chk("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, e.data});
            end
        end else begin
            chk("mem_en_low", {31'd0, bus.mem_en}, 32'd0);
            chk("idle_bus_zero", {17'd0, bus.mem_addr, bus.mem_wr, bus.mem_wdata}, 32'd0);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic w, input logic [DATA_W-1:0] d);
        ent_t e;
        logic exp_rdy;
        exp_rdy    = (mdl.size() < DEPTH);
        push_valid = 1'b1;
        push_addr  = a;
        push_wr    = w;
        push_data  = d;
        chk("push_ready", {31'd0, bus.push_ready}, {31'd0, exp_rdy});
        if (exp_rdy) begin
            e.addr = a;
            e.wr   = w;
            e.data = d;
            mdl.push_back(e);
        end
        tick();
        push_valid = 1'b0;
    endtask

    task automatic enqueue(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mdl[i % mdl.size()]);
    endtask

    task automatic load5();
        for (int i = 0; i < 5; i++) push(a5[i], w5[i], 8'hA0 + 8'(i));
    endtask

    // Clocks until done rises; returns clocks taken, bounded by a budget.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_count"}, {28'd0, count}, 32'd0);
        chk({tag, "_pass"}, {16'd0, pass_cnt}, 32'd0);
        chk({tag, "_push_ready"}, {31'd0, bus.push_ready}, 32'd1);
        chk({tag, "_mem_en"}, {31'd0, bus.mem_en}, 32'd0);
        chk({tag, "_mem_bus"}, {17'd0, bus.mem_addr, bus.mem_wr, bus.mem_wdata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // basic non-loop replay
        load5();
        chk("count_after_load", {28'd0, count}, 32'd5);
        start = 1'b1;
        enqueue(5);
        tick();
        start = 1'b0;
        chk("busy_in_run", {31'd0, busy}, 32'd1);
        chk("push_ready_in_run", {31'd0, bus.push_ready}, 32'd0);
        wait_done(n);
        chk("done_latency", n, 32'd5);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("pass_single", {16'd0, pass_cnt}, 32'd1);
        chk("queue_drained_1", exp_q.size(), 32'd0);
        chk("count_retained", {28'd0, count}, 32'd5);

        // replay from DONE gives the identical sequence
        start = 1'b1;
        enqueue(5);
        tick();
        start = 1'b0;
        wait_done(n);
        chk("replay_latency", n, 32'd5);
        chk("replay_pass", {16'd0, pass_cnt}, 32'd1);
        chk("queue_drained_2", exp_q.size(), 32'd0);

        // loop for 12 entries then stop
        loop_en = 1'b1;
        start = 1'b1;
        enqueue(12);
        tick();
        start = 1'b0;
        repeat (11) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        chk("loop_stop_done", {31'd0, done}, 32'd1);
        chk("loop_stop_busy", {31'd0, busy}, 32'd0);
        chk("loop_pass", {16'd0, pass_cnt}, 32'd2);
        chk("loop_pass_small", {30'd0, pass_s}, 32'd2);
        chk("queue_drained_3", exp_q.size(), 32'd0);

        // clear beats start in DONE; start with empty buffer is ignored
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        mdl.delete();
        chk("clear_state_done", {31'd0, done}, 32'd0);
        chk("clear_busy", {31'd0, busy}, 32'd0);
        chk("clear_count", {28'd0, count}, 32'd0);
        start = 1'b1;
        push(6'd33, 1'b1, 8'h5A);
        start = 1'b0;
        chk("empty_start_busy", {31'd0, busy}, 32'd0);
        chk("empty_start_count", {28'd0, count}, 32'd1);
        start = 1'b1;
        enqueue(1);
        tick();
        start = 1'b0;
        chk("single_pass", {16'd0, pass_cnt}, 32'd1);
        wait_done(n);
        chk("single_latency", n, 32'd1);
        chk("queue_drained_4", exp_q.size(), 32'd0);

        // fill past DEPTH with push_valid held
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mdl.delete();
        for (int i = 0; i < DEPTH + 2; i++) push(6'(3 * i + 1), i[0], 8'hC0 + 8'(i));
        chk("fill_count", {28'd0, count}, DEPTH);
        chk("fill_push_ready", {31'd0, bus.push_ready}, 32'd0);
        start = 1'b1;
        enqueue(DEPTH);
        tick();
        start = 1'b0;
        wait_done(n);
        chk("fill_latency", n, DEPTH);
        chk("fill_pass", {16'd0, pass_cnt}, 32'd1);
        chk("queue_drained_5", exp_q.size(), 32'd0);

        // reset in the middle of a run
        start = 1'b1;
        enqueue(3);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl.delete();
        chk_reset_outputs("midrun_rst");
        chk("queue_drained_6", exp_q.size(), 32'd0);

        // saturation of the 2-bit pass counter over 5 loop passes
        load5();
        loop_en = 1'b1;
        start = 1'b1;
        enqueue(25);
        tick();
        start = 1'b0;
        repeat (24) tick();
        chk("sat_pass_small", {30'd0, pass_s}, 32'd3);
        chk("sat_pass_wide", {16'd0, pass_cnt}, 32'd5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        chk("sat_done", {31'd0, done}, 32'd1);
        chk("queue_drained_7", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
